// File: rtl/i1_router_pkg.sv
// Shared flit-type codes, per-VC state encoding and error codes for the
// router input-port VC write controller.
package i1_router_pkg;

    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b110;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    // Per-VC update requested by the top-level decode for the addressed VC.
    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_OPEN  = 2'd1,
        CMD_INC   = 2'd2,
        CMD_CLOSE = 2'd3
    } vc_cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_HEAD_ACTIVE = 2'd1,
        ERR_IDLE_VC     = 2'd2,
        ERR_BAD_FLIT    = 2'd3
    } err_code_e;

endpackage

// File: rtl/i1_router_vc_wrctrl_if.sv
// Upstream flit handshake plus the per-VC FIFO write/full port.
// master = flit source / FIFO side, slave = the write controller.
interface i1_router_vc_wrctrl_if #(
    parameter int NUM_VC = 4,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic              input_req;
    logic [2:0]        head;
    logic [VC_W-1:0]   vc_sel;
    logic              input_bussy;
    logic [NUM_VC-1:0] FIFO_full;
    logic [NUM_VC-1:0] FIFO_wr;

    modport master (
        output input_req, head, vc_sel, FIFO_full,
        input  input_bussy, FIFO_wr
    );

    modport slave (
        input  input_req, head, vc_sel, FIFO_full,
        output input_bussy, FIFO_wr
    );
endinterface

// File: rtl/i1_router_vc_pktfsm.sv
// One virtual channel's packet tracker: IDLE/ACTIVE state plus flit counter,
// advanced by the command the top-level decode issues for this VC.
module i1_router_vc_pktfsm
    import i1_router_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  vc_cmd_e          cmd,
    output logic             active,
    output logic [CNT_W-1:0] cnt
);

    vc_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= VC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults are assigned first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (cmd)
            CMD_OPEN: begin
                state_nxt = VC_ACTIVE;
                cnt_nxt   = CNT_W'(1);
            end
            CMD_INC:   cnt_nxt = cnt + CNT_W'(1);
            CMD_CLOSE: begin
                state_nxt = VC_IDLE;
                cnt_nxt   = '0;
            end
            default: ;
        endcase
    end

    assign active = (state == VC_ACTIVE);

endmodule

// File: rtl/i1_router_vc_wrctrl.sv
// Router input-port VC write controller: decodes the incoming flit, accepts it
// into the addressed VC FIFO or drops it, and records the first protocol error.
module i1_router_vc_wrctrl
    import i1_router_pkg::*;
#(
    parameter  int NUM_VC      = 4,
    parameter  int MAX_PKT_LEN = 16,
    localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    i1_router_vc_wrctrl_if.slave bus,
    input  logic                err_clr,
    output logic [NUM_VC-1:0]   vc_active,
    output logic                proto_err,
    output logic [1:0]          err_code
);

    localparam logic [CNT_W-1:0] LAST_BODY_CNT = CNT_W'(MAX_PKT_LEN - 1);

    logic [CNT_W-1:0] vc_cnt [NUM_VC];
    vc_cmd_e          vc_cmd [NUM_VC];

    logic             vc_ok, sel_active, sel_full;
    logic [CNT_W-1:0] sel_cnt;
    logic             is_head, is_body, is_tail;
    logic             flit_valid, overflow, accept, drop;
    err_code_e        drop_code;
    logic [NUM_VC-1:0] wr;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        i1_router_vc_pktfsm #(.CNT_W(CNT_W)) u_pktfsm (
            .clk    (clk),
            .rst    (rst),
            .cmd    (vc_cmd[g]),
            .active (vc_active[g]),
            .cnt    (vc_cnt[g])
        );
    end

    // Select by match rather than indexing so out-of-range vc_sel reads nothing.
    always_comb begin
        vc_ok      = 1'b0;
        sel_active = 1'b0;
        sel_full   = 1'b0;
        sel_cnt    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (bus.vc_sel == VC_W'(i)) begin
                vc_ok      = 1'b1;
                sel_active = vc_active[i];
                sel_full   = bus.FIFO_full[i];
                sel_cnt    = vc_cnt[i];
            end
        end
    end

    assign is_head = (bus.head == FLIT_HEAD);
    assign is_body = (bus.head == FLIT_BODY);
    assign is_tail = (bus.head == FLIT_TAIL);

    always_comb begin
        drop_code = ERR_NONE;
        if (!vc_ok || !(is_head || is_body || is_tail))
            drop_code = ERR_BAD_FLIT;
        else if (is_head && sel_active)
            drop_code = ERR_HEAD_ACTIVE;
        else if (!is_head && !sel_active)
            drop_code = ERR_IDLE_VC;
        else if (is_body && sel_cnt == LAST_BODY_CNT)
            drop_code = ERR_BAD_FLIT;
    end

    // Reset masks the request so the port looks busy and writes nothing.
    assign flit_valid = bus.input_req && !rst;
    assign drop       = flit_valid && (drop_code != ERR_NONE);
    assign accept     = flit_valid && (drop_code == ERR_NONE) && !sel_full;
    assign overflow   = drop && vc_ok && is_body && sel_active
                        && (sel_cnt == LAST_BODY_CNT);

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_cmd[i] = CMD_NOP;
            if (bus.vc_sel == VC_W'(i)) begin
                wr[i] = accept;
                if (accept)
                    vc_cmd[i] = is_head ? CMD_OPEN : (is_body ? CMD_INC : CMD_CLOSE);
                else if (overflow)
                    vc_cmd[i] = CMD_CLOSE;
            end
        end
    end

    assign bus.FIFO_wr     = wr;
    assign bus.input_bussy = !(accept || drop);

    // A new drop outranks a same-cycle clear; the code only moves when free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (drop) begin
            proto_err <= 1'b1;
            if (!proto_err || err_clr)
                err_code <= drop_code;
        end else if (err_clr) begin
            proto_err <= 1'b0;
        end
    end

endmodule

// File: doc/i1_router_vc_wrctrl.md
I1_ROUTER_VC_WRCTRL -- requirements
Module: i1_router_vc_wrctrl

Interface
REQ-001 Parameter NUM_VC, default 4, number of virtual channels / input FIFOs (1..16).
REQ-002 Parameter MAX_PKT_LEN, default 16, maximum flits per packet including head and tail (2..255).
REQ-003 Derived VC_W = max(1, clog2(NUM_VC)); CNT_W = clog2(MAX_PKT_LEN+1).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 input_req  input  1  upstream flit valid.
REQ-007 head  input  3  flit type: 3'b001 HEAD, 3'b010 BODY, 3'b110 TAIL, all other codes illegal.
REQ-008 vc_sel  input  VC_W  target VC of the current flit.
REQ-009 FIFO_full  input  NUM_VC  per-VC FIFO full flags.
REQ-010 err_clr  input  1  clears the sticky error, synchronous.
REQ-011 FIFO_wr  output  NUM_VC  one-hot write strobe to the selected FIFO.
REQ-012 input_bussy  output  1  upstream hold: flit not consumed this cycle.
REQ-013 vc_active  output  NUM_VC  per-VC packet-in-progress flag.
REQ-014 proto_err  output  1  sticky protocol-error flag.
REQ-015 err_code  output  2  code of the first error since the last clear.

Function
REQ-016 Each VC SHALL hold one FSM, IDLE or ACTIVE, plus a CNT_W-bit flit counter; vc_active[i] = (state_i == ACTIVE).
REQ-017 Legal flit: HEAD with target VC in IDLE; BODY or TAIL with target VC in ACTIVE; vc_sel < NUM_VC.
REQ-018 Accept = input_req & legal & ~FIFO_full[vc_sel]; FIFO_wr[vc_sel] = accept, combinational, zero latency; all other FIFO_wr bits 0.
REQ-019 input_bussy = 1 when input_req=0, or when a legal flit's FIFO_full[vc_sel]=1; 0 when a flit is accepted or dropped.
REQ-020 Illegal flit with input_req=1 SHALL be dropped in that cycle: no FIFO_wr, input_bussy=0, error recorded; dropping SHALL NOT depend on FIFO_full.
REQ-021 Accepted HEAD: VC -> ACTIVE, counter <= 1.
REQ-022 Accepted BODY: counter += 1, VC stays ACTIVE.
REQ-023 Accepted TAIL: VC -> IDLE, counter <= 0.
REQ-024 BODY arriving with counter = MAX_PKT_LEN-1 is a length overflow: dropped, VC -> IDLE, counter <= 0; TAIL at that count is legal.
REQ-025 Error codes: 2'd1 HEAD to ACTIVE VC (VC state unchanged); 2'd2 BODY/TAIL to IDLE VC; 2'd3 length overflow, illegal type code, or vc_sel >= NUM_VC.
REQ-026 proto_err sets on any drop, cleared by err_clr; set wins over a same-cycle clear; err_code latches only when proto_err is 0 or is cleared that cycle.
REQ-027 Only the VC addressed by vc_sel changes state in a cycle; VCs are fully independent, so packets may interleave at flit granularity.
REQ-028 A full FIFO on one VC SHALL NOT block flits addressed to other VCs.

Reset
REQ-029 While rst=1: all VCs IDLE, counters 0, proto_err 0, err_code 0, FIFO_wr all 0, input_bussy 1, vc_active 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release, the next flit on that VC must be a HEAD.

Structure
REQ-031 Package i1_router_pkg SHALL hold the flit type constants (HEAD/BODY/TAIL), the FSM state encoding, and the err_code values.
REQ-032 Per-VC FSM and counter SHALL be sub-module i1_router_vc_pktfsm, generated NUM_VC times; the top level holds decode, accept, and the error logic.

Verification
REQ-033 NUM_VC=4: HEAD, BODY, TAIL on vc 2, FIFOs not full -> FIFO_wr=4'b0100 in each of the 3 cycles, vc_active[2] 1 then 0 after TAIL, proto_err=0.
REQ-034 FIFO_full[1]=1 with HEAD on vc 1 for 3 cycles, then full drops -> input_bussy=1 and FIFO_wr=0 for 3 cycles, then a single write 4'b0010.
REQ-035 BODY to IDLE vc 0 -> FIFO_wr=0, input_bussy=0, proto_err=1, err_code=2; then HEAD to ACTIVE vc 3 -> err_code stays 2; err_clr -> proto_err=0.
REQ-036 MAX_PKT_LEN=4: HEAD plus 3 BODY on vc 0 -> third BODY dropped, err_code=3, vc_active[0]=0; HEAD plus 2 BODY plus TAIL -> all 4 written.
REQ-037 Interleave HEAD vc0, HEAD vc1, TAIL vc0, TAIL vc1 while FIFO_full[0] is held during the first TAIL -> vc1 flits written unblocked, vc0 TAIL written after full drops.
REQ-038 rst asserted with vc 2 ACTIVE at counter 5 -> after release vc_active=0; BODY to vc 2 -> err_code=2.
